// File: rtl/dsp_pkg.sv
// Shared types and constants for the channelizer signal chain and the
// blocks that consume its per-channel output.
package dsp_pkg;

  localparam int chan_power_width              = 16;
  localparam int CHANNELIZER_INDEX_WIDTH       = 8;
  localparam int CHAN_PWR_INTEGRATION_LOG2_MAX = 8;

  typedef struct packed {
    logic                               valid;
    logic [CHANNELIZER_INDEX_WIDTH-1:0] data_index;
  } channelizer_control_t;

  typedef struct packed {
    logic                               valid;
    logic [CHANNELIZER_INDEX_WIDTH-1:0] index;
    logic [chan_power_width-1:0]        pwr_avg;
    logic [chan_power_width-1:0]        pwr_peak;
  } chan_pwr_report_t;

  typedef enum logic {
    CPI_SYNC = 1'b0,
    CPI_RUN  = 1'b1
  } chan_pwr_state_t;

endpackage

// File: rtl/chan_pwr_integrator_mem.sv
// Per-channel accumulator store: simple dual-port RAM with one write port
// and one registered read port, left unreset so it maps onto RAM primitives.
module chan_pwr_integrator_mem #(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH = 36
) (
  input  logic                  Clk,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge Clk) begin
    rd_data <= mem_r[rd_addr];
  end

endmodule

// File: rtl/chan_pwr_integrator.sv
// Per-channel power integrator: accumulates mean and peak power of each channel
// over 2^INTEGRATION_LOG2 frames and reports every channel in the last frame.
module chan_pwr_integrator
  import dsp_pkg::*;
#(
  parameter int NUM_CHANNELS        = 32,
  parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
  parameter int POWER_WIDTH         = chan_power_width,
  parameter int INTEGRATION_LOG2    = 4
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           Enable,
  input  channelizer_control_t           Input_ctrl,
  input  logic [POWER_WIDTH-1:0]         Input_pwr,
  output logic                           Output_valid,
  output logic [CHANNEL_INDEX_WIDTH-1:0] Output_index,
  output logic [POWER_WIDTH-1:0]         Output_pwr_avg,
  output logic [POWER_WIDTH-1:0]         Output_pwr_peak,
  output logic                           Error_index_sequence
);

  localparam int ACC_WIDTH = POWER_WIDTH + INTEGRATION_LOG2;
  localparam int MEM_WIDTH = ACC_WIDTH + POWER_WIDTH;

  localparam logic [CHANNEL_INDEX_WIDTH-1:0]     IDX_ZERO   = {CHANNEL_INDEX_WIDTH{1'b0}};
  localparam logic [CHANNEL_INDEX_WIDTH-1:0]     IDX_ONE    = CHANNEL_INDEX_WIDTH'(1);
  localparam logic [CHANNEL_INDEX_WIDTH-1:0]     IDX_LAST   = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [CHANNELIZER_INDEX_WIDTH-1:0] CTRL_ZERO  = {CHANNELIZER_INDEX_WIDTH{1'b0}};
  localparam logic [INTEGRATION_LOG2-1:0]        FRAME_ZERO = {INTEGRATION_LOG2{1'b0}};
  localparam logic [INTEGRATION_LOG2-1:0]        FRAME_ONE  = INTEGRATION_LOG2'(1);
  localparam logic [INTEGRATION_LOG2-1:0]        FRAME_LAST = {INTEGRATION_LOG2{1'b1}};
  localparam logic [POWER_WIDTH-1:0]             PWR_ZERO   = {POWER_WIDTH{1'b0}};

  chan_pwr_state_t                state_r;
  logic [CHANNEL_INDEX_WIDTH-1:0] exp_index_r;
  logic [INTEGRATION_LOG2-1:0]    frame_r;

  logic [CHANNEL_INDEX_WIDTH-1:0] in_index_s;
  logic                           in_valid_s;
  logic                           index_zero_s;
  logic                           in_order_s;
  logic                           accept_s;
  logic                           restart_s;
  logic                           seq_err_s;
  logic [INTEGRATION_LOG2-1:0]    sample_frame_s;

  logic                           s1_valid_r;
  logic                           s1_first_r;
  logic                           s1_last_r;
  logic [CHANNEL_INDEX_WIDTH-1:0] s1_index_r;
  logic [POWER_WIDTH-1:0]         s1_pwr_r;

  logic [MEM_WIDTH-1:0]           rd_data_s;
  logic [MEM_WIDTH-1:0]           wr_data_s;
  logic                           wr_en_s;
  logic [ACC_WIDTH-1:0]           rd_acc_s;
  logic [ACC_WIDTH-1:0]           acc_sum_s;
  logic [POWER_WIDTH-1:0]         rd_peak_s;
  logic [POWER_WIDTH-1:0]         peak_s;
  logic [POWER_WIDTH-1:0]         avg_s;
  logic                           report_s;

  assign in_index_s = Input_ctrl.data_index[CHANNEL_INDEX_WIDTH-1:0];

  // Accept/reject the incoming sample and decide which frame it belongs to
  always_comb begin
    in_valid_s   = Enable & Input_ctrl.valid;
    index_zero_s = (Input_ctrl.data_index == CTRL_ZERO);
    in_order_s   = (Input_ctrl.data_index == CHANNELIZER_INDEX_WIDTH'(exp_index_r));
    accept_s     = 1'b0;
    restart_s    = 1'b0;
    seq_err_s    = 1'b0;
    if (!in_valid_s) begin
      accept_s = 1'b0;
    end else if (state_r == CPI_SYNC) begin
      accept_s  = index_zero_s;
      restart_s = index_zero_s;
    end else if (in_order_s) begin
      accept_s = 1'b1;
    end else begin
      // An early index 0 still flags the break but immediately opens a new period.
      seq_err_s = 1'b1;
      accept_s  = index_zero_s;
      restart_s = index_zero_s;
    end
    if (restart_s) begin
      sample_frame_s = FRAME_ZERO;
    end else begin
      sample_frame_s = frame_r;
    end
  end

  // Sequencing FSM with expected-index and frame counters
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= CPI_SYNC;
      exp_index_r <= IDX_ZERO;
      frame_r     <= FRAME_ZERO;
    end else if (!Enable) begin
      state_r     <= CPI_SYNC;
      exp_index_r <= IDX_ZERO;
      frame_r     <= FRAME_ZERO;
    end else if (accept_s) begin
      state_r     <= CPI_RUN;
      exp_index_r <= in_index_s + IDX_ONE;
      if (in_index_s == IDX_LAST) begin
        frame_r <= sample_frame_s + FRAME_ONE;
      end else begin
        frame_r <= sample_frame_s;
      end
    end else if (seq_err_s) begin
      state_r     <= CPI_SYNC;
      exp_index_r <= IDX_ZERO;
      frame_r     <= FRAME_ZERO;
    end
  end

  // Sample stage aligned with the registered memory read
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_index_r <= IDX_ZERO;
      s1_pwr_r   <= PWR_ZERO;
    end else begin
      s1_valid_r <= accept_s;
      s1_first_r <= (sample_frame_s == FRAME_ZERO);
      s1_last_r  <= (sample_frame_s == FRAME_LAST);
      s1_index_r <= in_index_s;
      s1_pwr_r   <= Input_pwr;
    end
  end

  chan_pwr_integrator_mem #(
    .DEPTH      (NUM_CHANNELS),
    .ADDR_WIDTH (CHANNEL_INDEX_WIDTH),
    .DATA_WIDTH (MEM_WIDTH)
  ) u_mem (
    .Clk     (Clk),
    .rd_addr (in_index_s),
    .rd_data (rd_data_s),
    .wr_en   (wr_en_s),
    .wr_addr (s1_index_r),
    .wr_data (wr_data_s)
  );

  assign rd_acc_s  = rd_data_s[MEM_WIDTH-1:POWER_WIDTH];
  assign rd_peak_s = rd_data_s[POWER_WIDTH-1:0];

  // Accumulate/max datapath; frame 0 overwrites so the memory never needs clearing
  always_comb begin
    if (s1_first_r) begin
      acc_sum_s = ACC_WIDTH'(s1_pwr_r);
      peak_s    = s1_pwr_r;
    end else begin
      acc_sum_s = rd_acc_s + ACC_WIDTH'(s1_pwr_r);
      if (s1_pwr_r > rd_peak_s) begin
        peak_s = s1_pwr_r;
      end else begin
        peak_s = rd_peak_s;
      end
    end
    avg_s     = POWER_WIDTH'(acc_sum_s >> INTEGRATION_LOG2);
    report_s  = s1_valid_r & s1_last_r;
    wr_en_s   = s1_valid_r & ~s1_last_r;
    wr_data_s = {acc_sum_s, peak_s};
  end

  // Registered report and error outputs; Enable low squashes anything in flight
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Output_valid         <= 1'b0;
      Output_index         <= IDX_ZERO;
      Output_pwr_avg       <= PWR_ZERO;
      Output_pwr_peak      <= PWR_ZERO;
      Error_index_sequence <= 1'b0;
    end else if (!Enable) begin
      Output_valid         <= 1'b0;
      Output_index         <= IDX_ZERO;
      Output_pwr_avg       <= PWR_ZERO;
      Output_pwr_peak      <= PWR_ZERO;
      Error_index_sequence <= 1'b0;
    end else begin
      Error_index_sequence <= seq_err_s;
      Output_valid         <= report_s;
      if (report_s) begin
        Output_index    <= s1_index_r;
        Output_pwr_avg  <= avg_s;
        Output_pwr_peak <= peak_s;
      end else begin
        Output_index    <= IDX_ZERO;
        Output_pwr_avg  <= PWR_ZERO;
        Output_pwr_peak <= PWR_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_chan_pwr_integrator.sv
// Directed, table-driven bench for chan_pwr_integrator with 8 channels and
// 4-frame integration periods.
module tb_chan_pwr_integrator;
  import dsp_pkg::*;

  localparam int NCH  = 8;
  localparam int LOG2 = 2;
  localparam int PW   = chan_power_width;
  localparam int MAXV = 1024;

  logic                 Clk = 1'b0;
  logic                 Rst_n;
  logic                 Enable;
  channelizer_control_t Input_ctrl;
  logic [PW-1:0]        Input_pwr;
  logic                 Output_valid;
  logic [2:0]           Output_index;
  logic [PW-1:0]        Output_pwr_avg;
  logic [PW-1:0]        Output_pwr_peak;
  logic                 Error_index_sequence;

  chan_pwr_integrator #(
    .NUM_CHANNELS     (NCH),
    .INTEGRATION_LOG2 (LOG2)
  ) dut (
    .Clk                  (Clk),
    .Rst_n                (Rst_n),
    .Enable               (Enable),
    .Input_ctrl           (Input_ctrl),
    .Input_pwr            (Input_pwr),
    .Output_valid         (Output_valid),
    .Output_index         (Output_index),
    .Output_pwr_avg       (Output_pwr_avg),
    .Output_pwr_peak      (Output_pwr_peak),
    .Error_index_sequence (Error_index_sequence)
  );

  always #5 Clk = ~Clk;

  // One row per clock: inputs driven in that cycle, outputs expected in that cycle.
  typedef struct {
    int            tag;
    logic          rst_n;
    logic          en;
    logic          valid;
    logic [7:0]    idx;
    logic [PW-1:0] pwr;
    logic          exp_v;
    logic [2:0]    exp_idx;
    logic [PW-1:0] exp_avg;
    logic [PW-1:0] exp_peak;
    logic          exp_err;
    logic          chk_all;
  } vec_t;

  vec_t  tbl [MAXV];
  int    n_vec;
  int    cur_tag;
  int    checks;
  int    failures;
  string names [8];
  int    pat [4];
  int    ch3 [4];

  task automatic chk(string scen, string what, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s row %0d: got %0h expected %0h", scen, what, row, act, exp);
    end
  endtask

  function automatic void put(logic v, int idx, int pwr);
    tbl[n_vec].tag   = cur_tag;
    tbl[n_vec].valid = v;
    tbl[n_vec].idx   = 8'(idx);
    tbl[n_vec].pwr   = PW'(pwr);
    n_vec++;
  endfunction

  function automatic void expect_rep(int at, int idx, int avg, int peak);
    tbl[at].exp_v    = 1'b1;
    tbl[at].exp_idx  = 3'(idx);
    tbl[at].exp_avg  = PW'(avg);
    tbl[at].exp_peak = PW'(peak);
  endfunction

  // One valid sample followed by `gap` idle cycles; its report is due 2 rows later.
  function automatic void sample(int idx, int pwr, int gap, bit rep, int avg, int peak);
    if (rep) expect_rep(n_vec + 2, idx, avg, peak);
    put(1'b1, idx, pwr);
    for (int g = 0; g < gap; g++) put(1'b0, 0, 0);
  endfunction

  function automatic void period_const(int p, int gap);
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < NCH; c++)
        sample(c, p, gap, f == 3, p, p);
  endfunction

  // Channel 3 sees 10,20,30,41 (sum 101 -> avg 25, peak 41); all others stay at 0.
  function automatic void period_ch3(int gap);
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < NCH; c++)
        sample(c, (c == 3) ? ch3[f] : 0, gap, f == 3, (c == 3) ? 25 : 0, (c == 3) ? 41 : 0);
  endfunction

  // Channel c sees 5+c,6+c,7+c,9+c: sum 27+4c -> avg 6+c, peak 9+c.
  function automatic void period_pat(int gap, bit err_first);
    if (err_first) tbl[n_vec + 1].exp_err = 1'b1;
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < NCH; c++)
        sample(c, pat[f] + c, gap, f == 3, 6 + c, 9 + c);
  endfunction

  function automatic void put_rst();
    tbl[n_vec].rst_n   = 1'b0;
    tbl[n_vec].chk_all = 1'b1;
    put(1'b0, 0, 0);
  endfunction

  function automatic void put_en0(int idx);
    tbl[n_vec].en      = 1'b0;
    tbl[n_vec].chk_all = 1'b1;
    put(1'b1, idx, 100);
  endfunction

  initial begin
    names = '{"const100", "ch3_b2b", "ch3_gap3", "all_ones",
              "bad_seq", "idx0_inject", "reset_f3", "enable_f2"};
    pat   = '{5, 6, 7, 9};
    ch3   = '{10, 20, 30, 41};
    for (int i = 0; i < MAXV; i++) begin
      tbl[i].tag      = 0;
      tbl[i].rst_n    = 1'b1;
      tbl[i].en       = 1'b1;
      tbl[i].valid    = 1'b0;
      tbl[i].idx      = 8'd0;
      tbl[i].pwr      = '0;
      tbl[i].exp_v    = 1'b0;
      tbl[i].exp_idx  = 3'd0;
      tbl[i].exp_avg  = '0;
      tbl[i].exp_peak = '0;
      tbl[i].exp_err  = 1'b0;
      tbl[i].chk_all  = 1'b0;
    end
    n_vec = 0;

    cur_tag = 0; period_const(100, 0);
    cur_tag = 1; period_ch3(0);
    cur_tag = 2; period_ch3(3);
    cur_tag = 3; period_const(65535, 0);

    cur_tag = 4;
    put(1'b1, 0, 1); put(1'b1, 1, 1); put(1'b1, 2, 1);
    tbl[n_vec + 1].exp_err = 1'b1;
    put(1'b1, 4, 1);
    put(1'b1, 3, 1); put(1'b1, 5, 1); put(1'b0, 0, 0);
    period_pat(0, 1'b0);

    cur_tag = 5;
    for (int c = 0; c < NCH; c++) sample(c, 50, 0, 1'b0, 0, 0);
    for (int c = 0; c < 4; c++) sample(c, 50, 0, 1'b0, 0, 0);
    period_pat(0, 1'b1);

    cur_tag = 6;
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < NCH; c++) sample(c, 100, 0, 1'b0, 0, 0);
    sample(0, 100, 0, 1'b1, 100, 100);
    sample(1, 100, 0, 1'b0, 0, 0);
    sample(2, 100, 0, 1'b0, 0, 0);
    put_rst(); put_rst();
    for (int c = 3; c < NCH; c++) put(1'b1, c, 100);
    period_pat(0, 1'b0);

    cur_tag = 7;
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < NCH; c++) sample(c, 100, 0, 1'b0, 0, 0);
    for (int c = 0; c < 4; c++) sample(c, 100, 0, 1'b0, 0, 0);
    put_en0(4); put_en0(5);
    put(1'b1, 6, 100); put(1'b1, 7, 100);
    period_pat(0, 1'b0);

    checks   = 0;
    failures = 0;
    Rst_n    = 1'b0;
    Enable   = 1'b1;
    Input_ctrl.valid      = 1'b0;
    Input_ctrl.data_index = 8'd0;
    Input_pwr = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset", "valid", 0, 32'(Output_valid), 32'd0);
    chk("reset", "index", 0, 32'(Output_index), 32'd0);
    chk("reset", "avg",   0, 32'(Output_pwr_avg), 32'd0);
    chk("reset", "peak",  0, 32'(Output_pwr_peak), 32'd0);
    chk("reset", "err",   0, 32'(Error_index_sequence), 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    for (int i = 0; i < n_vec + 3; i++) begin
      @(posedge Clk); #1;
      Rst_n                 = tbl[i].rst_n;
      Enable                = tbl[i].en;
      Input_ctrl.valid      = tbl[i].valid;
      Input_ctrl.data_index = tbl[i].idx;
      Input_pwr             = tbl[i].pwr;
      @(negedge Clk);
      chk(names[tbl[i].tag], "valid", i, 32'(Output_valid), 32'(tbl[i].exp_v));
      chk(names[tbl[i].tag], "err",   i, 32'(Error_index_sequence), 32'(tbl[i].exp_err));
      if (tbl[i].exp_v || tbl[i].chk_all) begin
        chk(names[tbl[i].tag], "index", i, 32'(Output_index), 32'(tbl[i].exp_idx));
        chk(names[tbl[i].tag], "avg",   i, 32'(Output_pwr_avg), 32'(tbl[i].exp_avg));
        chk(names[tbl[i].tag], "peak",  i, 32'(Output_pwr_peak), 32'(tbl[i].exp_peak));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
